// File: rtl/argmax_scan_controller.sv
// Sequences one argmax datapath over a multi-chunk vector: clear, stream num_chunks beats, capture result.
// Optional stall timeout in SCAN is compiled in when ARGMAX_TIMEOUT_EN is defined.
module argmax_scan_controller #(
   parameter int WIDTH          = 8,
   parameter int ARGMAX_WIDTH   = 8,
   parameter int CNT_WIDTH      = 5,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [CNT_WIDTH-1:0]    i_num_chunks,
   output logic                    o_busy,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic                    o_dp_clear,
   output logic                    o_dp_enable,
   input  logic [ARGMAX_WIDTH-1:0] i_dp_argmax,
   input  logic [WIDTH-1:0]        i_dp_max,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [ARGMAX_WIDTH-1:0] o_res_argmax,
   output logic [WIDTH-1:0]        o_res_max,
   output logic [CNT_WIDTH-1:0]    o_res_count,
   output logic                    o_res_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t                 r_state, w_next;
   logic [CNT_WIDTH-1:0]   r_num;
   logic [CNT_WIDTH-1:0]   r_beat;
   logic                   w_go;
   logic                   w_hs;
   logic                   w_last;
   logic                   w_tmo;

   assign w_go   = (r_state == S_IDLE) && i_start && (i_num_chunks != '0);
   assign w_hs   = (r_state == S_SCAN) && i_in_valid;
   assign w_last = w_hs && (r_beat == r_num - CNT_WIDTH'(1));

`ifdef ARGMAX_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0] r_stall;
   logic               r_to;
   logic               r_res_to;

   // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
   assign w_tmo = (r_state == S_SCAN) && !w_hs &&
                  (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall  <= '0;
         r_to     <= 1'b0;
         r_res_to <= 1'b0;
      end else begin
         if (w_go) begin
            r_stall <= '0;
            r_to    <= 1'b0;
         end else if (r_state == S_SCAN) begin
            r_stall <= w_hs ? '0 : r_stall + STALL_W'(1);
            if (w_tmo) r_to <= 1'b1;
         end
         if (r_state == S_DRAIN) r_res_to <= r_to;
      end
   end

   assign o_res_timeout = r_res_to;
`else
   assign w_tmo         = 1'b0;
   assign o_res_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_CLEAR;
         S_CLEAR: w_next = S_SCAN;
         S_SCAN:  if (w_last || w_tmo) w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  if (i_res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != S_IDLE);
      o_in_ready  = (r_state == S_SCAN);
      o_dp_clear  = (r_state == S_CLEAR);
      o_dp_enable = w_hs;
      o_res_valid = (r_state == S_DONE);
   end

   // Datapath registers its result one cycle after the last enable, so DRAIN sees final values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num        <= '0;
         r_beat       <= '0;
         o_res_argmax <= '0;
         o_res_max    <= '0;
         o_res_count  <= '0;
      end else begin
         if (w_go) begin
            r_num  <= i_num_chunks;
            r_beat <= '0;
         end else if (w_hs) begin
            r_beat <= r_beat + CNT_WIDTH'(1);
         end
         if (r_state == S_DRAIN) begin
            o_res_argmax <= i_dp_argmax;
            o_res_max    <= i_dp_max;
            o_res_count  <= r_beat;
         end
      end
   end

endmodule

// File: tb/tb_argmax_scan_controller.sv
// Randomized bench for argmax_scan_controller with a behavioural 4-lane argmax datapath stub.
module tb_argmax_scan_controller;
   localparam int W  = 8;
   localparam int AW = 8;
   localparam int CW = 5;
   localparam int L  = 4;
`ifdef ARGMAX_TIMEOUT_EN
   localparam int TO = 10;
`else
   localparam int TO = 255;
`endif

   typedef logic [L-1:0][7:0] beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [CW-1:0] i_num_chunks;
   logic          o_busy;
   logic          i_in_valid;
   logic          o_in_ready;
   logic          o_dp_clear;
   logic          o_dp_enable;
   logic [AW-1:0] dp_arg;
   logic [W-1:0]  dp_max;
   logic          o_res_valid;
   logic          i_res_ready;
   logic [AW-1:0] o_res_argmax;
   logic [W-1:0]  o_res_max;
   logic [CW-1:0] o_res_count;
   logic          o_res_timeout;

   beat_t         tb_lanes;
   logic [7:0]    dp_chunk;
   logic [7:0]    ref_q[$];
   beat_t         beats[$];
   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   argmax_scan_controller #(.WIDTH(W), .ARGMAX_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_num_chunks(i_num_chunks), .o_busy(o_busy),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_dp_clear(o_dp_clear),
      .o_dp_enable(o_dp_enable), .i_dp_argmax(dp_arg), .i_dp_max(dp_max),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_argmax(o_res_argmax),
      .o_res_max(o_res_max), .o_res_count(o_res_count), .o_res_timeout(o_res_timeout));

   function automatic logic [23:0] fold(input logic [7:0] m, input logic [7:0] a,
                                        input logic [7:0] c, input beat_t d);
      for (int i = 0; i < L; i++)
         if ($signed(d[i]) > $signed(m)) begin
            m = d[i];
            a = 8'(c * L + i);
         end
      return {m, a, c + 8'd1};
   endfunction

   // Datapath stub: registered running max with first-occurrence argmax, cleared to most negative.
   always @(posedge clk) begin
      if (o_dp_clear) begin
         dp_max   <= 8'h80;
         dp_arg   <= 8'h00;
         dp_chunk <= 8'h00;
      end else if (o_dp_enable) begin
         {dp_max, dp_arg, dp_chunk} <= fold(dp_max, dp_arg, dp_chunk, tb_lanes);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ref_result(output logic [7:0] m, output logic [7:0] a);
      m = 8'h80;
      a = 8'h00;
      for (int i = 0; i < ref_q.size(); i++)
         if ($signed(ref_q[i]) > $signed(m)) begin
            m = ref_q[i];
            a = 8'(i);
         end
   endtask

   task automatic make_beats(input int n, input bit directed);
      beat_t b;
      beats.delete();
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < L; i++)
            b[i] = directed ? 8'($urandom_range(136) - 100) : 8'($urandom);
         beats.push_back(b);
      end
      if (directed && n > 2) beats[2][1] = 8'd37;
   endtask

   task automatic start_scan(input int n);
      ref_q.delete();
      chk("idle_busy", o_busy, 0);
      i_start = 1'b1;
      i_num_chunks = CW'(n);
      step();
      i_start = 1'b0;
      i_num_chunks = CW'($urandom);
      chk("clear_pulse", o_dp_clear, 1);
      chk("clear_busy", o_busy, 1);
      chk("clear_ready", o_in_ready, 0);
      step();
      chk("clear_once", o_dp_clear, 0);
   endtask

   // Sends beats[0..n-1]; optional forced gap before beat gap_at; random stalls capped at 4 in a row.
   task automatic send_beats(input int n, input int stall_pct, input int gap_at, input int gap_len);
      int sent = 0, cyc = 0, run = 0, gap = gap_len;
      bit v;
      while (sent < n && cyc < 2000) begin
         if (sent == gap_at && gap > 0) begin
            v = 1'b0;
            gap--;
         end else begin
            v = (run >= 4) || ($urandom_range(99) >= stall_pct);
         end
         run = v ? 0 : run + 1;
         i_in_valid = v;
         tb_lanes = beats[sent];
         #1;
         chk("scan_ready", o_in_ready, 1);
         chk("dp_enable", o_dp_enable, v);
         if (v) begin
            for (int i = 0; i < L; i++) ref_q.push_back(beats[sent][i]);
            sent++;
         end
         step();
         cyc++;
      end
      i_in_valid = 1'b0;
      if (sent < n) chk("send_budget", sent, n);
   endtask

   task automatic finish_scan(input int n, input int hold, input bit exp_to);
      logic [7:0] em, ea;
      ref_result(em, ea);
      chk("drain_valid", o_res_valid, 0);
      chk("drain_ready", o_in_ready, 0);
      chk("drain_busy", o_busy, 1);
      step();
      chk("res_valid", o_res_valid, 1);
      chk("res_argmax", o_res_argmax, ea);
      chk("res_max", o_res_max, em);
      chk("res_count", o_res_count, n);
      chk("res_timeout", o_res_timeout, exp_to);
      for (int h = 0; h < hold; h++) begin
         i_res_ready = 1'b0;
         i_start = 1'b1;
         i_num_chunks = CW'($urandom_range(1, 31));
         step();
         chk("hold_valid", o_res_valid, 1);
         chk("hold_busy", o_busy, 1);
         chk("hold_noclear", o_dp_clear, 0);
         chk("hold_argmax", o_res_argmax, ea);
         chk("hold_max", o_res_max, em);
         chk("hold_count", o_res_count, n);
      end
      i_start = 1'b0;
      i_res_ready = 1'b1;
      step();
      i_res_ready = 1'b0;
      chk("back_idle", o_busy, 0);
      chk("back_valid", o_res_valid, 0);
   endtask

   task automatic run_scan(input int n, input int stall_pct, input int gap_at, input int gap_len,
                           input int hold, input bit directed);
      make_beats(n, directed);
      start_scan(n);
      send_beats(n, stall_pct, gap_at, gap_len);
      finish_scan(n, hold, 1'b0);
   endtask

   initial begin
      logic [7:0] em, ea;
      rst = 1'b1;
      i_start = 1'b0;
      i_num_chunks = '0;
      i_in_valid = 1'b0;
      i_res_ready = 1'b0;
      tb_lanes = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_in_ready, 0);
      chk("rst_clear", o_dp_clear, 0);
      chk("rst_valid", o_res_valid, 0);
      chk("rst_count", o_res_count, 0);
      chk("rst_max", o_res_max, 0);

      // Back-to-back scan, max 37 at element 9.
      run_scan(4, 0, -1, 0, 0, 1'b1);
      chk("t1_arg", o_res_argmax, 9);
      chk("t1_max", o_res_max, 37);
      // Same shape with a 3-cycle gap before beat 3, then 5 held DONE cycles with start pulses.
      run_scan(4, 0, 2, 3, 5, 1'b1);
      chk("t2_arg", o_res_argmax, 9);

      // Reset after 2 of 6 beats.
      make_beats(6, 1'b0);
      start_scan(6);
      send_beats(2, 0, -1, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_valid", o_res_valid, 0);
      chk("abort_ready", o_in_ready, 0);
      step();
      chk("abort_stay", o_busy, 0);
      run_scan(6, 20, -1, 0, 1, 1'b0);

      // num_chunks == 0 is ignored.
      i_start = 1'b1;
      i_num_chunks = '0;
      step();
      i_start = 1'b0;
      chk("zero_busy", o_busy, 0);
      chk("zero_clear", o_dp_clear, 0);
      step();
      chk("zero_stay", o_busy, 0);

      for (int s = 0; s < 20; s++)
         run_scan($urandom_range(1, 31), $urandom_range(0, 50), -1, 0, $urandom_range(0, 3), 1'b0);
      run_scan(31, 10, -1, 0, 0, 1'b0);

      // One of three beats then silence.
      make_beats(3, 1'b0);
      start_scan(3);
      send_beats(1, 0, -1, 0);
`ifdef ARGMAX_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         chk("to_wait", o_res_valid, 0);
         step();
      end
      finish_scan(1, 0, 1'b1);
      // Timeout with no beats: cleared datapath values.
      make_beats(2, 1'b0);
      start_scan(2);
      for (int k = 0; k < TO; k++) step();
      ref_result(em, ea);
      chk("to0_ref", {em, ea}, 16'h8000);
      finish_scan(0, 0, 1'b1);
`else
      for (int k = 0; k < 100; k++) step();
      chk("stall_busy", o_busy, 1);
      chk("stall_ready", o_in_ready, 1);
      chk("stall_valid", o_res_valid, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("stall_rst", o_busy, 0);
`endif
      run_scan(5, 30, -1, 0, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
